gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Parametrised, self-sequencing successor to the two-input NAND exercise. On `start`, the block exhaustively sweeps all 2^N input combinations through a selectable N-input reduction gate. Each gate output is compared against a caller-supplied expected truth table; the block counts mismatches and records the first failing combination. It sits beside the Guia gate exercises as a reusable hardware checker, replacing hand-written per-vector testbench checks.

Parameters:
- `N`, default 2: number of gate inputs, legal range 1..8.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a sweep. Sampled only in IDLE.
- `clear`, input, 1: synchronous abort/clear. Returns to IDLE and zeroes results.
- `op`, input, 3: gate select. 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 reserved.
- `exp`, input, 2^N: expected truth table; `exp[i]` is the expected output for combination i.
- `vec`, output, N: combination currently under test. `vec[N-1]` is the MSB input ("a" for N=2).
- `gate_out`, output, 1: combinational gate result for the current `vec` and latched `op`.
- `busy`, output, 1: high in SWEEP.
- `done`, output, 1: one-cycle pulse in DONE.
- `pass`, output, 1: high when the last completed sweep had zero mismatches.
- `fail_cnt`, output, N+1: mismatch count of the current or last sweep.
- `first_fail`, output, N: lowest mismatching index; meaningful only when `fail_cnt != 0`.
- `err`, output, 1: one-cycle pulse when `start` is given with a reserved `op`.

Behaviour:
- **Reset (`rst_n` = 0, asynchronous):**
  - state = IDLE.
  - `vec`, `fail_cnt`, `first_fail`, latched `op`/`exp` = 0.
  - `busy`, `done`, `pass`, `err` = 0.
  - Reset asserted mid-sweep aborts immediately; no `done` is produced.
- **States:** IDLE, SWEEP, DONE.
- **IDLE:**
  - `start` = 1 with `op` ≤ 5: latch `op` and `exp`, clear `fail_cnt`/`first_fail`/`pass`, set `vec` = 0, go to SWEEP.
  - `start` = 1 with `op` ≥ 6: `err` = 1 for one cycle, stay in IDLE, results unchanged.
- **SWEEP:** every edge:
  - Compare `gate_out` against latched `exp[vec]`.
  - On mismatch: `fail_cnt` += 1. If it is the first mismatch of the sweep, `first_fail` = `vec`.
  - If `vec` = 2^N−1: go to DONE, `vec` holds. Otherwise `vec` += 1 (no wrap inside the sweep).
- **DONE:**
  - `done` = 1 and `pass` = (`fail_cnt` == 0), both valid this cycle.
  - Next edge returns to IDLE. `pass`, `fail_cnt`, `first_fail` hold until the next accepted `start` or `clear`.
- **Latency:** edge sampling `start` = E0. `done` is visible in the cycle after edge E(2^N), exactly 2^N cycles after E0.
- **Gate function:** reduction over all N bits of `vec`. NAND = ~&, NOR = ~|, AND = &, OR = |, XOR = ^, XNOR = ~^. For N = 1, AND/OR/XOR reduce to identity and NAND/NOR/XNOR to inversion.
- **`start` while busy or in DONE:** ignored. Changes to `op`/`exp` during a sweep have no effect.
- **`clear`:** has priority over `start` and sweep progress. Any state goes to IDLE; `vec`, `fail_cnt`, `first_fail`, `pass` = 0; no `done`.
- **`fail_cnt` width:** N+1 bits, so the maximum value 2^N cannot overflow.

Test Plan:
1. N=2, `op`=0 (NAND), `exp`=4'b0111, pulse `start` → `vec` steps 0,1,2,3; `gate_out` = 1,1,1,0; `done` 4 cycles after start; `pass`=1, `fail_cnt`=0.
2. N=2, `op`=0, `exp`=4'b1111 → `done`, `pass`=0, `fail_cnt`=1, `first_fail`=3.
3. N=2, `op`=4 (XOR), `exp`=4'b0000 → `fail_cnt`=2, `first_fail`=1; then `op`=5, `exp`=4'b1001 → `pass`=1.
4. N=3, `op`=1 (NOR), `exp`=8'b0000_0001 → `pass`=1 after 8 cycles. With `exp`=8'hFE → `fail_cnt`=8 (max), `first_fail`=0.
5. `op`=6 with `start` in IDLE → `err` pulse of 1 cycle, `busy` stays 0. A second `start` while `busy` → ignored, only one `done`.
6. N=2 sweep: drop `rst_n` at `vec`=2 → all outputs 0 immediately, no `done`. Separate run: `clear` at `vec`=1 → IDLE next cycle, `fail_cnt`=0.

Source files
------------

// File: rtl/gate_sweep_checker_if.sv
// Bus bundle for gate_sweep_checker: sweep control and truth table in, sweep
// position, gate result and verdict out.
interface gate_sweep_checker_if #(
  parameter int N = 2
);
  logic              start;
  logic              clear;
  logic [2:0]        op;
  logic [2**N-1:0]   exp;
  logic [N-1:0]      vec;
  logic              gate_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N:0]        fail_cnt;
  logic [N-1:0]      first_fail;
  logic              err;

  modport master (
    output start, clear, op, exp,
    input  vec, gate_out, busy, done, pass, fail_cnt, first_fail, err
  );

  modport slave (
    input  start, clear, op, exp,
    output vec, gate_out, busy, done, pass, fail_cnt, first_fail, err
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive checker: sweeps all 2^N inputs through a selectable N-input
// reduction gate and compares each result against a caller truth table.
module gate_sweep_checker #(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_sweep_checker_if.slave bus
);
  localparam int            NumCombos = 2**N;
  localparam logic [N-1:0]  LastVec   = '1;
  localparam logic [N-1:0]  VecOne    = N'(1);
  localparam logic [N:0]    CntOne    = (N+1)'(1);
  localparam logic [2:0]    MaxOp     = 3'd5;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [NumCombos-1:0]   exp_q, exp_d;
  logic [N-1:0]           vec_q, vec_d;
  logic [N:0]             fail_cnt_q, fail_cnt_d;
  logic [N-1:0]           first_fail_q, first_fail_d;
  logic                   pass_q, pass_d;
  logic                   err_q, err_d;
  logic                   gate_val;
  logic                   mismatch;

  // NOTE: a default before the case keeps reserved op codes from inferring a latch.
  always_comb begin
    gate_val = 1'b0;
    unique case (op_q)
      3'd0:    gate_val = ~&vec_q;
      3'd1:    gate_val = ~|vec_q;
      3'd2:    gate_val =  &vec_q;
      3'd3:    gate_val =  |vec_q;
      3'd4:    gate_val =  ^vec_q;
      3'd5:    gate_val = ~^vec_q;
      default: gate_val = 1'b0;
    endcase
  end

  assign mismatch = gate_val != exp_q[vec_q];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    exp_d        = exp_q;
    vec_d        = vec_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    err_d        = 1'b0;

    if (bus.clear) begin
      state_d      = IDLE;
      vec_d        = '0;
      fail_cnt_d   = '0;
      first_fail_d = '0;
      pass_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.op <= MaxOp) begin
              state_d      = SWEEP;
              op_d         = bus.op;
              exp_d        = bus.exp;
              vec_d        = '0;
              fail_cnt_d   = '0;
              first_fail_d = '0;
              pass_d       = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        SWEEP: begin
          if (mismatch) begin
            fail_cnt_d = fail_cnt_q + CntOne;
            if (fail_cnt_q == '0) first_fail_d = vec_q;
          end
          // The last combination parks vec so the failing index stays readable.
          if (vec_q == LastVec) begin
            state_d = DONE;
            pass_d  = (fail_cnt_d == '0);
          end else begin
            vec_d = vec_q + VecOne;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      exp_q        <= '0;
      vec_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      exp_q        <= exp_d;
      vec_q        <= vec_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.gate_out   = gate_val;
  assign bus.busy       = (state_q == SWEEP);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker (N=2 and N=3 instances) with a
// truth-table model checked every cycle plus hand-computed literal checks.
module tb_gate_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  gate_sweep_checker_if #(.N(2)) bus2 ();
  gate_sweep_checker_if #(.N(3)) bus3 ();

  gate_sweep_checker #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  gate_sweep_checker #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // mode: 0 idle, 1 sweeping, 2 done; k = combinations already judged;
  // mm = mismatch map of the whole latched table, computed at acceptance.
  typedef struct {
    int       n;
    int       mode;
    int       pos;
    int       k;
    int       op;
    logic [7:0] mm;
    bit       pass;
    bit       err;
  } model_t;

  model_t m [2];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Gate result from the count of ones, independent of reduction operators.
  function automatic bit ref_gate(input int op, input int v, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (op)
      0: return !(ones == n);
      1: return !(ones > 0);
      2: return ones == n;
      3: return ones > 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int prefix_cnt(input int d, input int k);
    int c = 0;
    for (int i = 0; i < k; i++) c += int'(m[d].mm[i]);
    return c;
  endfunction

  function automatic int prefix_first(input int d, input int k);
    for (int i = 0; i < k; i++) if (m[d].mm[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].n = (d == 0) ? 2 : 3;
      m[d].mode = 0; m[d].pos = 0; m[d].k = 0; m[d].op = 0;
      m[d].mm = '0; m[d].pass = 1'b0; m[d].err = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit start, input bit clear,
                            input int op, input logic [7:0] e);
    int last = (1 << m[d].n) - 1;
    int was  = m[d].mode;
    m[d].err = 1'b0;
    if (clear) begin
      m[d].mode = 0; m[d].pos = 0; m[d].k = 0; m[d].pass = 1'b0;
    end else if (was == 1) begin
      m[d].k++;
      if (m[d].pos == last) begin
        m[d].mode = 2;
        m[d].pass = (prefix_cnt(d, m[d].k) == 0);
      end else begin
        m[d].pos++;
      end
    end else if (was == 2) begin
      m[d].mode = 0;
    end else if (start) begin
      if (op <= 5) begin
        m[d].op = op;
        for (int i = 0; i <= last; i++) m[d].mm[i] = ref_gate(op, i, m[d].n) != e[i];
        m[d].mode = 1; m[d].pos = 0; m[d].k = 0; m[d].pass = 1'b0;
      end else begin
        m[d].err = 1'b1;
      end
    end
  endtask

  task automatic compare_dut(input int d, input int vec, input int g, input int busy,
                             input int done, input int pass, input int fc,
                             input int ff, input int err);
    int efc = prefix_cnt(d, m[d].k);
    string p = (d == 0) ? "n2" : "n3";
    check({p, ".vec"},      vec,  m[d].pos);
    check({p, ".gate_out"}, g,    int'(ref_gate(m[d].op, m[d].pos, m[d].n)));
    check({p, ".busy"},     busy, int'(m[d].mode == 1));
    check({p, ".done"},     done, int'(m[d].mode == 2));
    check({p, ".pass"},     pass, int'(m[d].pass));
    check({p, ".fail_cnt"}, fc,   efc);
    if (efc != 0) check({p, ".first_fail"}, ff, prefix_first(d, m[d].k));
    check({p, ".err"},      err,  int'(m[d].err));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        model_step(0, bus2.start, bus2.clear, int'(bus2.op), {4'b0, bus2.exp});
        model_step(1, bus3.start, bus3.clear, int'(bus3.op), bus3.exp);
      end
      #1;
      if (chk_en) begin
        compare_dut(0, int'(bus2.vec), int'(bus2.gate_out), int'(bus2.busy), int'(bus2.done),
                    int'(bus2.pass), int'(bus2.fail_cnt), int'(bus2.first_fail), int'(bus2.err));
        compare_dut(1, int'(bus3.vec), int'(bus3.gate_out), int'(bus3.busy), int'(bus3.done),
                    int'(bus3.pass), int'(bus3.fail_cnt), int'(bus3.first_fail), int'(bus3.err));
      end
    end
  end

  function automatic int get_done(input int d);
    return (d == 0) ? int'(bus2.done) : int'(bus3.done);
  endfunction
  function automatic int get_fail(input int d);
    return (d == 0) ? int'(bus2.fail_cnt) : int'(bus3.fail_cnt);
  endfunction
  function automatic int get_first(input int d);
    return (d == 0) ? int'(bus2.first_fail) : int'(bus3.first_fail);
  endfunction
  function automatic int get_pass(input int d);
    return (d == 0) ? int'(bus2.pass) : int'(bus3.pass);
  endfunction

  // Pulses start for one cycle; returns at the negedge just after the sampling edge.
  task automatic drive_start(input int d, input logic [2:0] op, input logic [7:0] e);
    @(negedge clk);
    if (d == 0) begin
      bus2.op = op; bus2.exp = e[3:0]; bus2.start = 1'b1;
    end else begin
      bus3.op = op; bus3.exp = e; bus3.start = 1'b1;
    end
    @(negedge clk);
    bus2.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic run_sweep(input int d, input logic [2:0] op, input logic [7:0] e);
    int cnt = 0;
    drive_start(d, op, e);
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (get_done(d) == 1) break;
    end
    if (get_done(d) != 1) check("done_timeout", 0, 1);
    else check("latency", cnt, (d == 0) ? 4 : 8);
  endtask

  task automatic count_done(input int d, input int cycles, output int dones);
    dones = 0;
    repeat (cycles) begin
      @(negedge clk);
      dones += get_done(d);
    end
  endtask

  initial begin
    int gexp [4] = '{1, 1, 1, 0};
    int dones;
    bus2.start = 1'b0; bus2.clear = 1'b0; bus2.op = '0; bus2.exp = '0;
    bus3.start = 1'b0; bus3.clear = 1'b0; bus3.op = '0; bus3.exp = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset.busy", int'(bus2.busy), 0);
    check("reset.vec", int'(bus2.vec), 0);
    check("reset.fail_cnt", int'(bus2.fail_cnt), 0);
    check("reset.pass", int'(bus2.pass), 0);

    // Plan 1: NAND, table 0111.
    drive_start(0, 3'd0, 8'h07);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("t1.vec", int'(bus2.vec), i);
      check("t1.gate_out", int'(bus2.gate_out), gexp[i]);
    end
    @(negedge clk);
    check("t1.done", int'(bus2.done), 1);
    check("t1.pass", get_pass(0), 1);
    check("t1.fail_cnt", get_fail(0), 0);

    // Plan 2: NAND, table 1111 -> only combination 3 mismatches.
    run_sweep(0, 3'd0, 8'h0F);
    check("t2.pass", get_pass(0), 0);
    check("t2.fail_cnt", get_fail(0), 1);
    check("t2.first_fail", get_first(0), 3);

    // Plan 3: XOR against all-zero, then XNOR against 1001.
    run_sweep(0, 3'd4, 8'h00);
    check("t3.fail_cnt", get_fail(0), 2);
    check("t3.first_fail", get_first(0), 1);
    run_sweep(0, 3'd5, 8'h09);
    check("t3.pass", get_pass(0), 1);

    // Plan 4: N=3 NOR, exact table then fully inverted table.
    run_sweep(1, 3'd1, 8'h01);
    check("t4.pass", get_pass(1), 1);
    run_sweep(1, 3'd1, 8'hFE);
    check("t4.fail_cnt", get_fail(1), 8);
    check("t4.first_fail", get_first(1), 0);
    check("t4.pass_low", get_pass(1), 0);

    // Plan 5: reserved op, then a second start while busy.
    @(negedge clk);
    drive_start(0, 3'd6, 8'h00);
    check("t5.err", int'(bus2.err), 1);
    check("t5.busy", int'(bus2.busy), 0);
    @(negedge clk);
    check("t5.err_pulse", int'(bus2.err), 0);
    drive_start(0, 3'd2, 8'h08);
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    count_done(0, 10, dones);
    check("t5.one_done", dones, 1);
    check("t5.pass", get_pass(0), 1);

    // Plan 6a: asynchronous reset at vec=2.
    drive_start(0, 3'd0, 8'h00);
    repeat (2) @(negedge clk);
    check("t6.vec_before", int'(bus2.vec), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_vec", int'(bus2.vec), 0);
    check("t6.rst_busy", int'(bus2.busy), 0);
    check("t6.rst_fail", int'(bus2.fail_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(0, 8, dones);
    check("t6.no_done_rst", dones, 0);

    // Plan 6b: clear at vec=1 after combination 0 already mismatched.
    drive_start(0, 3'd0, 8'h00);
    @(negedge clk);
    check("t6.vec1", int'(bus2.vec), 1);
    check("t6.fail_pre", int'(bus2.fail_cnt), 1);
    bus2.clear = 1'b1;
    @(negedge clk);
    bus2.clear = 1'b0;
    check("t6.clr_busy", int'(bus2.busy), 0);
    check("t6.clr_fail", int'(bus2.fail_cnt), 0);
    check("t6.clr_vec", int'(bus2.vec), 0);
    count_done(0, 6, dones);
    check("t6.no_done_clr", dones, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
